// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: upstream FIFO read port and downstream valid/ready stream of fifo_burst_reader.
interface fifo_burst_reader_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic [DW-1:0] fifo_q;
    logic          fifo_empty;
    logic [AW-1:0] fifo_usedw;
    logic          fifo_rdreq;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    modport master (
        input  fifo_q, fifo_empty, fifo_usedw, m_ready,
        output fifo_rdreq, m_data, m_valid, m_last, busy
    );
    modport slave (
        output fifo_q, fifo_empty, fifo_usedw, m_ready,
        input  fifo_rdreq, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads BURST_LEN-word bursts from a non-show-ahead FIFO into a 2-entry skid buffer.
// Define FIFO_BURST_READER_CSUM_EN to append a modulo-2^DW checksum word to every burst.
module fifo_burst_reader #(
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fifo_burst_reader_if.master bus
);
`ifdef FIFO_BURST_READER_CSUM_EN
    typedef enum logic [1:0] {IDLE, READ, DRAIN, CSUM} state_t;
    logic [DW-1:0] r_sum;
`else
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif
    state_t        r_state, w_next;
    logic [AW-1:0] r_issue, r_out;
    logic [1:0]    r_cnt, w_cnt_pop;
    logic          r_pend;
    logic [DW-1:0] r_buf0, r_buf1;
    logic          w_data_pop, w_rdreq, w_issue_last, w_out_last;

    assign w_data_pop   = (r_cnt != 2'd0) && bus.m_ready;
    assign w_cnt_pop    = r_cnt - {1'b0, w_data_pop};
    assign w_issue_last = r_issue == AW'(BURST_LEN - 1);
    assign w_out_last   = r_out == AW'(BURST_LEN - 1);
    // Slot accounting counts the word leaving this cycle, so reads stream back-to-back.
    assign w_rdreq      = (r_state == READ) && !bus.fifo_empty && (({1'b0, r_pend} + w_cnt_pop) < 2'd2);

    assign bus.fifo_rdreq = w_rdreq;
    assign bus.busy       = r_state != IDLE;
`ifdef FIFO_BURST_READER_CSUM_EN
    assign bus.m_valid    = (r_cnt != 2'd0) || (r_state == CSUM);
    assign bus.m_data     = (r_state == CSUM) ? r_sum : r_buf0;
    assign bus.m_last     = r_state == CSUM;
`else
    assign bus.m_valid    = r_cnt != 2'd0;
    assign bus.m_data     = r_buf0;
    assign bus.m_last     = (r_cnt != 2'd0) && w_out_last;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (bus.fifo_usedw >= AW'(BURST_LEN)) ? READ : IDLE;
            READ:    w_next = (w_rdreq && w_issue_last) ? DRAIN : READ;
`ifdef FIFO_BURST_READER_CSUM_EN
            DRAIN:   w_next = (w_data_pop && w_out_last) ? CSUM : DRAIN;
            CSUM:    w_next = bus.m_ready ? IDLE : CSUM;
`else
            DRAIN:   w_next = (w_data_pop && w_out_last) ? IDLE : DRAIN;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_issue <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
`ifdef FIFO_BURST_READER_CSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_pend  <= w_rdreq;
            r_issue <= (r_state == IDLE) ? '0 : r_issue + AW'(w_rdreq);
            r_out   <= (r_state == IDLE) ? '0 : r_out + AW'(w_data_pop);
            r_cnt   <= w_cnt_pop + {1'b0, r_pend};
            r_buf0  <= (r_pend && w_cnt_pop == 2'd0) ? bus.fifo_q : (w_data_pop ? r_buf1 : r_buf0);
            r_buf1  <= (r_pend && w_cnt_pop == 2'd1) ? bus.fifo_q : r_buf1;
`ifdef FIFO_BURST_READER_CSUM_EN
            r_sum   <= (r_state == IDLE) ? '0 : r_sum + (w_data_pop ? r_buf0 : '0);
`endif
        end
    end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DW, default 16, data width of the FIFO word.
REQ-002 SHALL have parameter AW, default 8, width of the FIFO fill-level input.
REQ-003 SHALL have parameter BURST_LEN, default 16, words per burst, legal range 1..2^AW-1.
REQ-004 Clk  input  1  single clock; all logic rising-edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 fifo_q  input  DW  upstream FIFO read data, valid one cycle after fifo_rdreq (non-show-ahead).
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_usedw  input  AW  upstream FIFO fill level.
REQ-009 fifo_rdreq  output  1  read strobe to upstream FIFO.
REQ-010 m_data  output  DW  downstream data.
REQ-011 m_valid  output  1  m_data valid.
REQ-012 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-013 m_last  output  1  high with the final word of a burst.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, READ, DRAIN, and CSUM when compiled in.
REQ-016 IDLE->READ SHALL occur when fifo_usedw >= BURST_LEN; no reads are issued in IDLE.
REQ-017 In READ, fifo_rdreq SHALL assert only when fifo_empty=0 and (outstanding reads + buffered words) < 2.
REQ-018 The output buffer SHALL be 2 entries (skid); a word returned by the FIFO is never dropped and never duplicated.
REQ-019 An issue counter SHALL count rdreq pulses per burst; after BURST_LEN pulses, READ->DRAIN with fifo_rdreq low.
REQ-020 Words SHALL leave on m_data in FIFO order; m_data/m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 Without CSUM, m_last SHALL be 1 on the BURST_LEN-th word; DRAIN->IDLE on its transfer.
REQ-022 Sustained throughput SHALL be one word per clock when m_ready=1 and the FIFO is not empty.
REQ-023 The rdreq-to-m_valid latency SHALL be 2 clocks from the rdreq edge to the first m_valid with an empty buffer.
REQ-024 fifo_empty asserting mid-burst SHALL pause rdreq, retain the state and counters, and resume when fifo_empty deasserts.
REQ-025 After a burst completes, the next burst SHALL start no earlier than the clock after return to IDLE.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 Rst_n low SHALL asynchronously force: state=IDLE, fifo_rdreq=0, m_valid=0, m_last=0, m_data=0, busy=0, counters=0, buffer emptied.
REQ-028 Reset mid-burst SHALL discard buffered and in-flight words; the next burst starts fresh from IDLE.

Configuration
REQ-029 Macro FIFO_BURST_READER_CSUM_EN defined: after the BURST_LEN-th data word transfers, DRAIN->CSUM emits one extra word.
REQ-030 That word SHALL be the modulo-2^DW sum of the burst's data words, with m_last=1 on it and not on the data word; CSUM->IDLE on transfer.
REQ-031 With the macro undefined: no CSUM state, no sum register, and the behaviour per REQ-021.

Verification
REQ-032 FIFO preloaded with 0..255, m_ready=1 -> 16 bursts of words 0..15, 16..31, ...; m_last on 15, 31, ..., 255; no gaps within a burst.
REQ-033 fifo_usedw=15 held -> fifo_rdreq stays 0 and busy=0; usedw raised to 16 -> fifo_rdreq asserts on the next clock.
REQ-034 m_ready toggling 1,0,0,1 mid-burst -> no lost or repeated word; m_data held stable during stall; at most 2 rdreq outstanding.
REQ-035 fifo_empty forced high for 5 clocks after 8 words -> rdreq paused; burst resumes with word 8; m_last on word 15.
REQ-036 Rst_n pulsed low after 5 words -> all outputs 0 immediately; after release the next burst starts from the current FIFO head.
REQ-037 CSUM_EN, burst of 1..16 -> 16 data words with m_last=0, then word 136 (0x0088) with m_last=1.
